decode_cycle: RTL and testbench

Instruction-decode stage of the five-stage RV32I pipeline, directly downstream of the fetch stage. Consumes the fetch stage's registered instruction, PC and PC+4. Decodes control, generates the sign-extended immediate and reads the 32×32 register file, which the write-back stage writes. Registers the result into the ID/EX pipeline register feeding execute, with a synchronous flush for hazard handling.

---
 rtl/decode_cycle.sv | 184 ++++++++++++++++++
 tb/tb_decode_cycle.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate generation, 32x32 register file, ID/EX register.
// Optional DECODE_WB_BYPASS_EN forwards a same-cycle write-back into RD1E/RD2E.
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic        IllegalE
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_d;
  logic        reg_write, mem_write, jump, branch, alu_src, illegal;
  logic [1:0]  result_src;
  logic [2:0]  alu_control, f3_alu;
  logic        f3_ok;
  logic [31:0] imm_ext;
  logic [31:0] rd1, rd2;
  logic [31:0] rf [0:31];

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rd_d   = InstrD[11:7];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  // funct3 -> ALU op shared by R and I-ALU; unlisted funct3 is illegal
  always_comb begin
    f3_ok  = 1'b1;
    f3_alu = 3'b000;
    case (funct3)
      3'b000:  f3_alu = 3'b000;
      3'b010:  f3_alu = 3'b101;
      3'b110:  f3_alu = 3'b011;
      3'b111:  f3_alu = 3'b010;
      default: f3_ok  = 1'b0;
    endcase
  end

  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    alu_src     = 1'b0;
    result_src  = 2'b00;
    alu_control = 3'b000;
    imm_ext     = 32'h0;
    illegal     = 1'b0;
    case (opcode)
      OP_R: begin
        if (f3_ok) begin
          reg_write   = 1'b1;
          alu_control = (funct3 == 3'b000 && InstrD[30]) ? 3'b001 : f3_alu;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_I: begin
        if (f3_ok) begin
          reg_write   = 1'b1;
          alu_src     = 1'b1;
          alu_control = f3_alu;
          imm_ext     = {{20{InstrD[31]}}, InstrD[31:20]};
        end else begin
          illegal = 1'b1;
        end
      end
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
        imm_ext    = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_ext   = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_BEQ: begin
        branch      = 1'b1;
        alu_control = 3'b001;
        imm_ext     = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        result_src = 2'b10;
        imm_ext    = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      end
      // all-zero word is the fetch stage's idle bubble, not an illegal instruction
      default: illegal = (InstrD != 32'h0);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (RegWriteW && RdW != 5'd0) begin
      rf[RdW] <= ResultW;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rd1 = (Rs1D == 5'd0) ? 32'h0 :
               (RegWriteW && RdW == Rs1D) ? ResultW : rf[Rs1D];
  assign rd2 = (Rs2D == 5'd0) ? 32'h0 :
               (RegWriteW && RdW == Rs2D) ? ResultW : rf[Rs2D];
`else
  assign rd1 = (Rs1D == 5'd0) ? 32'h0 : rf[Rs1D];
  assign rd2 = (Rs2D == 5'd0) ? 32'h0 : rf[Rs2D];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE) begin
      if (rst || FlushE) begin
        RegWriteE   <= 1'b0;
        MemWriteE   <= 1'b0;
        JumpE       <= 1'b0;
        BranchE     <= 1'b0;
        ALUSrcE     <= 1'b0;
        ResultSrcE  <= 2'b00;
        ALUControlE <= 3'b000;
        RD1E        <= 32'h0;
        RD2E        <= 32'h0;
        ImmExtE     <= 32'h0;
        PCE         <= 32'h0;
        PCPlus4E    <= 32'h0;
        Rs1E        <= 5'd0;
        Rs2E        <= 5'd0;
        RdE         <= 5'd0;
        IllegalE    <= 1'b0;
      end
    end else begin
      RegWriteE   <= reg_write;
      MemWriteE   <= mem_write;
      JumpE       <= jump;
      BranchE     <= branch;
      ALUSrcE     <= alu_src;
      ResultSrcE  <= result_src;
      ALUControlE <= alu_control;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= rd_d;
      IllegalE    <= illegal;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: control/immediate decode, register file, flush and reset.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .IllegalE(IllegalE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[2:0], Illegal}
  function automatic logic [31:0] ctrl_v(input logic rw, input logic mw, input logic j,
                                         input logic b, input logic as, input logic [1:0] rs,
                                         input logic [2:0] alu, input logic ill);
    return {21'b0, rw, mw, j, b, as, rs, alu, ill};
  endfunction

  function automatic logic [31:0] ctrl_e();
    return {21'b0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, IllegalE};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, ctrl_e(), 32'h0);
    check({tag, "_rd1"}, RD1E, 32'h0);
    check({tag, "_rd2"}, RD2E, 32'h0);
    check({tag, "_imm"}, ImmExtE, 32'h0);
    check({tag, "_pc"}, PCE, 32'h0);
    check({tag, "_pc4"}, PCPlus4E, 32'h0);
    check({tag, "_regs"}, {17'b0, Rs1E, Rs2E, RdE}, 32'h0);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    InstrD   = instr;
    PCD      = pc;
    PCPlus4D = pc + 32'd4;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    RegWriteW = we;
    RdW       = rd;
    ResultW   = data;
  endtask

  initial begin
    rst = 1'b1;
    FlushE = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    drive(32'h00028333, 32'h0);
    #2;
    check_all_zero("reset");
    check("rs1d_comb", {27'b0, Rs1D}, 32'd5);
    check("rs2d_comb", {27'b0, Rs2D}, 32'd0);
    step();
    rst = 1'b0;

    // ADDI x7,x0,100
    drive(32'h06400393, 32'h10);
    step();
    check("addi_ctrl", ctrl_e(), ctrl_v(1, 0, 0, 0, 1, 2'b00, 3'b000, 0));
    check("addi_imm", ImmExtE, 32'd100);
    check("addi_rd", {27'b0, RdE}, 32'd7);
    check("addi_rd1", RD1E, 32'h0);
    check("addi_pc4", PCPlus4E, 32'h14);

    // BEQ x0,x0,-8
    drive(32'hFE000CE3, 32'h20);
    step();
    check("beq_ctrl", ctrl_e(), ctrl_v(0, 0, 0, 1, 0, 2'b00, 3'b001, 0));
    check("beq_imm", ImmExtE, 32'hFFFFFFF8);
    check("beq_pc", PCE, 32'h20);
    check("beq_pc4", PCPlus4E, 32'h24);

    // write x5 alongside an all-zero bubble
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    drive(32'h0, 32'h0);
    step();
    check("zero_bubble", ctrl_e(), 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    drive(32'h00028333, 32'h24);
    step();
    check("add_ctrl", ctrl_e(), ctrl_v(1, 0, 0, 0, 0, 2'b00, 3'b000, 0));
    check("add_rd1", RD1E, 32'hDEADBEEF);
    check("add_rs1e", {27'b0, Rs1E}, 32'd5);
    check("add_rde", {27'b0, RdE}, 32'd6);
    check("add_imm", ImmExtE, 32'h0);

    // same-cycle write-back and read after reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    wb(1'b1, 5'd5, 32'h12345678);
    step();
`ifdef DECODE_WB_BYPASS_EN
    check("same_cycle_rd1", RD1E, 32'h12345678);
`else
    check("same_cycle_rd1", RD1E, 32'h0);
`endif
    wb(1'b0, 5'd0, 32'h0);
    step();
    check("after_write_rd1", RD1E, 32'h12345678);

    // write to x0 is ignored
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    drive(32'h0, 32'h0);
    step();
    wb(1'b0, 5'd0, 32'h0);
    drive(32'h00000333, 32'h0);
    step();
    check("x0_rd1", RD1E, 32'h0);
    check("x0_rd2", RD2E, 32'h0);

    // flush with a valid LW x1,4(x5), plus a write-back in the same cycle
    drive(32'h0042A083, 32'h40);
    FlushE = 1'b1;
    wb(1'b1, 5'd9, 32'hA5A5A5A5);
    step();
    check_all_zero("flush");
    FlushE = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    step();
    check("lw_ctrl", ctrl_e(), ctrl_v(1, 0, 0, 0, 1, 2'b01, 3'b000, 0));
    check("lw_imm", ImmExtE, 32'd4);
    check("lw_rd1", RD1E, 32'h12345678);
    drive(32'h00048333, 32'h44);
    step();
    check("flush_wb_rd1", RD1E, 32'hA5A5A5A5);

    // SW x5,-12(x2)
    drive(32'hFE512A23, 32'h48);
    step();
    check("sw_ctrl", ctrl_e(), ctrl_v(0, 1, 0, 0, 1, 2'b00, 3'b000, 0));
    check("sw_imm", ImmExtE, 32'hFFFFFFF4);
    check("sw_rd2", RD2E, 32'h12345678);

    // JAL x1,+2048
    drive(32'h001000EF, 32'h4C);
    step();
    check("jal_ctrl", ctrl_e(), ctrl_v(1, 0, 1, 0, 0, 2'b10, 3'b000, 0));
    check("jal_imm", ImmExtE, 32'h00000800);

    // ALU map: sub, I-ALU never sub, or, and, slt
    drive(32'h40028333, 32'h50);
    step();
    check("sub_alu", {29'b0, ALUControlE}, 32'd1);
    drive(32'h40000393, 32'h54);
    step();
    check("addi_b30_alu", {29'b0, ALUControlE}, 32'd0);
    check("addi_b30_imm", ImmExtE, 32'h400);
    drive(32'h0FF06393, 32'h58);
    step();
    check("ori_alu", {29'b0, ALUControlE}, 32'd3);
    drive(32'h00007333, 32'h5C);
    step();
    check("and_alu", {29'b0, ALUControlE}, 32'd2);
    drive(32'h00002333, 32'h60);
    step();
    check("slt_alu", {29'b0, ALUControlE}, 32'd5);

    // illegal encodings
    drive(32'h0000007F, 32'h64);
    step();
    check("bad_opcode", ctrl_e(), ctrl_v(0, 0, 0, 0, 0, 2'b00, 3'b000, 1));
    drive(32'h00001033, 32'h68);
    step();
    check("bad_funct3", ctrl_e(), ctrl_v(0, 0, 0, 0, 0, 2'b00, 3'b000, 1));

    // reset mid-stream clears outputs immediately and the register file
    drive(32'h0042A083, 32'h6C);
    step();
    check("pre_rst_ctrl", ctrl_e(), ctrl_v(1, 0, 0, 0, 1, 2'b01, 3'b000, 0));
    rst = 1'b1;
    FlushE = 1'b1;
    wb(1'b1, 5'd5, 32'h55555555);
    #1;
    check_all_zero("mid_rst");
    step();
    rst = 1'b0;
    FlushE = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    drive(32'h00028333, 32'h70);
    step();
    check("post_rst_rd1", RD1E, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
